// File: rtl/stereo_matrix_serial_gain_pkg.sv
// Shared constants and helpers for the stereo sum/difference gain stage.
// Holds state encodings, product width and output saturation limits.
package stereo_matrix_serial_gain_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL_S = 2'd1;
    localparam logic [1:0] ST_MUL_D = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int pw(input int dw, input int kw);
        return dw + kw;
    endfunction

    function automatic longint sat_max(input int ow);
        return (longint'(1) <<< (ow - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

endpackage

// File: rtl/serial_mult_core.sv
// LSB-first shift-add multiplier: signed multiplicand times unsigned multiplier.
// The load cycle already performs the first iteration, so a product needs KW edges.
module serial_mult_core
    import stereo_matrix_serial_gain_pkg::*;
#(
    parameter int DW = 18,
    parameter int KW = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic signed [DW-1:0]    multiplicand_i,
    input  logic [KW-1:0]           multiplier_i,
    output logic                    done_o,
    output logic signed [DW+KW-1:0] product_o
);

    localparam int PW = pw(DW, KW);
    localparam int CW = $clog2(KW + 1);

    logic signed [PW-1:0] acc_q, acc_d;
    logic signed [PW-1:0] mcand_q, mcand_d;
    logic signed [PW-1:0] mcand_ext;
    logic [KW-1:0]        mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 run_q, run_d;
    logic                 done_q, done_d;

    assign mcand_ext = PW'(multiplicand_i);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = done_q;
        if (load_i) begin
            acc_d    = multiplier_i[0] ? mcand_ext : '0;
            mcand_d  = mcand_ext <<< 1;
            mplier_d = multiplier_i >> 1;
            cnt_d    = CW'(1);
            run_d    = (KW > 1);
            done_d   = (KW == 1);
        end else if (run_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q <<< 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(KW - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/stereo_matrix_serial_gain.sv
// Stereo (L+R)/2 and (L-R)/2 with per-channel gain on one shared serial
// multiplier, fractional shift and saturation; adds mono and overrun flags.
module stereo_matrix_serial_gain
    import stereo_matrix_serial_gain_pkg::*;
#(
    parameter int DW   = 18,
    parameter int KW   = 4,
    parameter int FRAC = 3,
    parameter int OW   = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clken_48,
    input  logic signed [DW-1:0] left,
    input  logic signed [DW-1:0] right,
    input  logic [KW-1:0]        ks,
    input  logic [KW-1:0]        kd,
    input  logic                 mono,
    output logic signed [OW-1:0] lpr_out,
    output logic signed [OW-1:0] lmr_out,
    output logic                 valid_out,
    output logic                 busy,
    output logic                 overrun,
    output logic [1:0]           sat
);

    localparam int PW = pw(DW, KW);
    localparam logic signed [PW-1:0] SMAX = PW'(sat_max(OW));
    localparam logic signed [PW-1:0] SMIN = PW'(sat_min(OW));

    logic [1:0]           state_q, state_d;
    logic signed [DW-1:0] diff_q, diff_d;
    logic [KW-1:0]        kd_q, kd_d;
    logic                 mono_q, mono_d;
    logic signed [PW-1:0] prod_s_q, prod_s_d;
    logic signed [OW-1:0] lpr_q, lpr_d, lmr_q, lmr_d;
    logic [1:0]           sat_q, sat_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;

    logic signed [DW:0]   sum_w, diff_w;
    logic signed [DW-1:0] sum_c, diff_c;
    logic                 mul_load, mul_done;
    logic signed [DW-1:0] mul_a;
    logic [KW-1:0]        mul_b;
    logic signed [PW-1:0] mul_p;
    logic signed [PW-1:0] shs, shd;
    logic signed [OW-1:0] lpr_c, lmr_c;
    logic                 sat_s, sat_m;

    // Widen by one bit so the halving never overflows.
    assign sum_w  = {left[DW-1], left} + {right[DW-1], right};
    assign diff_w = {left[DW-1], left} - {right[DW-1], right};
    assign sum_c  = DW'(sum_w >>> 1);
    assign diff_c = DW'(diff_w >>> 1);

    assign mul_load = (state_q == ST_IDLE && clken_48)
                   || (state_q == ST_MUL_S && mul_done);
    assign mul_a = (state_q == ST_IDLE) ? sum_c : diff_q;
    assign mul_b = (state_q == ST_IDLE) ? ks : kd_q;

    serial_mult_core #(
        .DW(DW),
        .KW(KW)
    ) u_mult (
        .clk_i          (clock),
        .rst_i          (reset),
        .load_i         (mul_load),
        .multiplicand_i (mul_a),
        .multiplier_i   (mul_b),
        .done_o         (mul_done),
        .product_o      (mul_p)
    );

    assign shs = prod_s_q >>> FRAC;
    assign shd = mul_p >>> FRAC;

    always_comb begin
        sat_s = 1'b0;
        lpr_c = shs[OW-1:0];
        if (shs > SMAX) begin
            sat_s = 1'b1;
            lpr_c = SMAX[OW-1:0];
        end else if (shs < SMIN) begin
            sat_s = 1'b1;
            lpr_c = SMIN[OW-1:0];
        end
        sat_m = 1'b0;
        lmr_c = shd[OW-1:0];
        if (shd > SMAX) begin
            sat_m = 1'b1;
            lmr_c = SMAX[OW-1:0];
        end else if (shd < SMIN) begin
            sat_m = 1'b1;
            lmr_c = SMIN[OW-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        diff_d   = diff_q;
        kd_d     = kd_q;
        mono_d   = mono_q;
        prod_s_d = prod_s_q;
        lpr_d    = lpr_q;
        lmr_d    = lmr_q;
        sat_d    = sat_q;
        valid_d  = 1'b0;
        ovr_d    = clken_48 && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (clken_48) begin
                    state_d = ST_MUL_S;
                    diff_d  = diff_c;
                    kd_d    = kd;
                    mono_d  = mono;
                end
            end
            ST_MUL_S: begin
                if (mul_done) begin
                    state_d  = ST_MUL_D;
                    prod_s_d = mul_p;
                end
            end
            ST_MUL_D: begin
                if (mul_done) state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b1;
                lpr_d   = lpr_c;
                lmr_d   = mono_q ? '0 : lmr_c;
                sat_d   = {sat_s, sat_m && !mono_q};
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            diff_q   <= '0;
            kd_q     <= '0;
            mono_q   <= 1'b0;
            prod_s_q <= '0;
            lpr_q    <= '0;
            lmr_q    <= '0;
            sat_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            kd_q     <= kd_d;
            mono_q   <= mono_d;
            prod_s_q <= prod_s_d;
            lpr_q    <= lpr_d;
            lmr_q    <= lmr_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign lpr_out   = lpr_q;
    assign lmr_out   = lmr_q;
    assign sat       = sat_q;
    assign valid_out = valid_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/stereo_matrix_serial_gain.md
Name: stereo_matrix_serial_gain

Overview:
- Builds the stereo sum/difference signals from LEFT/RIGHT: halved L+R and halved L-R.
- Scales each by its own unsigned gain using one shared bit-serial shift-add multiplier, time-multiplexed across both channels.
- Applies a fixed fractional right shift, then saturates to the output width.
- Sits in the 48 kHz audio domain, ahead of the interpolators feeding the FM multiplex; adds a mono mode and overrun/saturation reporting.

Parameters:
- DW, 18: signed input sample width (LEFT/RIGHT) and internal sum/diff width.
- KW, 4: unsigned gain width (Ks/Kd); one multiplier iteration per gain bit.
- FRAC, 3: fractional bits of the gain; product is arithmetically right-shifted by FRAC.
- OW, 18: signed output width; saturation target.

Ports:
- clock  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- clken_48  in  1  sample strobe, one cycle wide; starts a conversion.
- left  in  DW  signed left sample; sampled on accepted strobe.
- right  in  DW  signed right sample; sampled on accepted strobe.
- ks  in  KW  unsigned sum gain; sampled on accepted strobe.
- kd  in  KW  unsigned difference gain; sampled on accepted strobe.
- mono  in  1  1 = force difference output to 0; sampled on accepted strobe.
- lpr_out  out  OW  signed scaled (L+R)/2.
- lmr_out  out  OW  signed scaled (L-R)/2.
- valid_out  out  1  one-cycle pulse when both outputs update.
- busy  out  1  high while a conversion is in progress.
- overrun  out  1  one-cycle pulse when a strobe arrives while busy.
- sat  out  2  [1] = lpr saturated, [0] = lmr saturated; held with the outputs.

Behaviour:
- Reset (synchronous, active-high): state IDLE; lpr_out=0, lmr_out=0, sat=0, valid_out=0, busy=0, overrun=0; all internal registers cleared.
- Reset mid-conversion aborts it; no valid_out is produced for the aborted sample.
- States: IDLE -> MUL_S -> MUL_D -> DONE -> IDLE.
- IDLE, on clken_48=1 (capture edge, edge 0):
  - sum = (left+right) computed in DW+1 bits, then arithmetic shift right by 1, giving DW bits (floor).
  - diff = (left-right) handled the same way.
  - Latch sum, diff, ks, kd, mono; go to MUL_S.
- MUL_S: KW cycles, LSB-first shift-add of sum * {0,ks}; accumulator is DW+KW signed bits. Then go to MUL_D.
- MUL_D: KW cycles, computing diff * {0,kd} on the same datapath.
- DONE: one cycle, then IDLE.
- Output update (edge 2*KW+1 after the capture edge; edge 9 for KW=4):
  - Each product is arithmetic-shifted right by FRAC (floor), then clamped to [-2^(OW-1), 2^(OW-1)-1].
  - lpr_out, lmr_out and sat update on this edge; valid_out is high for exactly that cycle.
  - Outputs hold until the next update.
- Mono: if the latched mono=1, lmr_out=0 and sat[0]=0 regardless of kd. MUL_D still runs, so latency is constant.
- Gain 0 gives output 0. Gains are never negative, since the operand is zero-extended to KW+1 bits.
- busy=1 in MUL_S, MUL_D and DONE.
- A strobe is accepted only in IDLE. A strobe in any other state is ignored, and overrun pulses on the next cycle. Minimum strobe spacing is 2*KW+2 cycles.
- A strobe and reset in the same cycle: reset wins, nothing is captured.
- Inputs may change freely after the capture edge; only latched values are used.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, MUL_S, MUL_D, DONE);
  - width function PW = DW+KW;
  - saturation limits SAT_MAX/SAT_MIN as functions of OW.
- One sub-module, serial_mult_core (parameters DW, KW):
  - interface: load, multiplicand, multiplier, done, product;
  - contains the shift-add accumulator and iteration counter;
  - instantiated once and reloaded per channel by the top FSM.
- Shift/saturation logic stays in the top level.

Test Plan:
1. Basic: left=1000, right=200, ks=8, kd=8 -> valid_out at edge 9, lpr_out=600, lmr_out=400, sat=00.
2. Floor rounding: left=-3, right=0, ks=1, kd=1 -> lpr_out=-1, lmr_out=-1.
3. Saturation: left=right=131071, ks=15 -> lpr_out=131071, sat[1]=1. Then left=right=-131072, ks=15 -> lpr_out=-131072, sat[1]=1.
4. Mono: left=1000, right=-1000, kd=15, mono=1 -> lmr_out=0, sat=00; same stimulus with mono=0 -> lmr_out=1875.
5. Overrun: second strobe 3 cycles after the first -> overrun pulse one cycle later, only one valid_out, results from the first sample only. Strobe at spacing 10 -> both samples accepted.
6. Reset at cycle 5 of a conversion -> no valid_out, busy=0, outputs 0; the next strobe converts normally.
